// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared definitions for the pushbutton conditioner. Provides
//               the per-channel FSM state type, the Basys3 button bit
//               positions, default timing constants and a small helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Per-channel press/hold/auto-repeat state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // Bit positions of the Basys3 buttons in the NUM_BTN-wide vectors.
    localparam int BTN_C = 4;
    localparam int BTN_U = 3;
    localparam int BTN_L = 2;
    localparam int BTN_R = 1;
    localparam int BTN_D = 0;

    // Default timing at a 100 MHz clock.
    localparam int DEF_NUM_BTN         = 5;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int DEF_HOLD_CYCLES     = 50_000_000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES   = 25_000_000;  // 250 ms (4 Hz)

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One pushbutton channel: 2-flop synchronizer, counter-based
//               debouncer and an IDLE/HOLD/REPEAT state machine producing
//               press, release and hold-to-auto-repeat pulses.
// Ports       : clk           - system clock
//               rst_n         - asynchronous active-low reset
//               raw           - raw asynchronous button level (active-high)
//               level         - debounced level (registered)
//               press         - one-cycle pulse on accepted press
//               release_pulse - one-cycle pulse on accepted release
//               repeat_pulse  - pulse on press, then auto-repeat while held
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,  // must be >= 2
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,      // must be >= 2
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES     // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    // One counter serves both HOLD and REPEAT, so it is sized for the larger.
    localparam int HR_W = max_int($clog2(HOLD_CYCLES), $clog2(REPEAT_CYCLES));

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HR_W-1:0] HOLD_LAST   = HR_W'(HOLD_CYCLES - 1);
    localparam logic [HR_W-1:0] REPEAT_LAST = HR_W'(REPEAT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: accept a new level only after it has differed from the
    // current debounced level for DEBOUNCE_CYCLES consecutive cycles.
    // Agreement is tested first, so a bounce back in the terminal cycle
    // still cancels the change.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (s2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            level  <= s2;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Press / hold / auto-repeat FSM
    // ------------------------------------------------------------------
    btn_state_t      state;
    btn_state_t      state_nxt;
    logic [HR_W-1:0] hr_cnt;
    logic [HR_W-1:0] hr_cnt_nxt;
    logic            press_nxt;
    logic            release_nxt;
    logic            repeat_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hr_cnt        <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            hr_cnt        <= hr_cnt_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        hr_cnt_nxt  = hr_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        repeat_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (level) begin
                    state_nxt  = HOLD;
                    hr_cnt_nxt = '0;
                    press_nxt  = 1'b1;
                    repeat_nxt = 1'b1;
                end
            end

            HOLD: begin
                // Release takes precedence over a terminal count.
                if (!level) begin
                    state_nxt   = IDLE;
                    hr_cnt_nxt  = '0;
                    release_nxt = 1'b1;
                end else if (hr_cnt == HOLD_LAST) begin
                    state_nxt  = REPEAT;
                    hr_cnt_nxt = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    hr_cnt_nxt = hr_cnt + HR_W'(1);
                end
            end

            REPEAT: begin
                if (!level) begin
                    state_nxt   = IDLE;
                    hr_cnt_nxt  = '0;
                    release_nxt = 1'b1;
                end else if (hr_cnt == REPEAT_LAST) begin
                    hr_cnt_nxt = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    hr_cnt_nxt = hr_cnt + HR_W'(1);
                end
            end

            default: begin
                state_nxt  = IDLE;
                hr_cnt_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions the Basys3 pushbuttons {C,U,L,R,D} = [4:0].
//               Each bit gets an independent synchronizer, debouncer and
//               press/hold/auto-repeat state machine.
// Ports       : clk         - 100 MHz system clock
//               rst_n       - asynchronous active-low reset
//               btn_raw     - raw pushbutton levels (active-high)
//               btn_level   - debounced levels
//               btn_press   - one-cycle pulse per accepted press
//               btn_release - one-cycle pulse per accepted release
//               btn_repeat  - pulse on press, then auto-repeat while held
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press         (btn_press[i]),
            .release_pulse (btn_release[i]),
            .repeat_pulse  (btn_repeat[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               short timing parameters. Expected output events are queued
//               when stimulus is applied and compared every cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
    import button_pkg::*;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    // Event kinds held in the scoreboard.
    localparam int EV_LVL_UP = 0;
    localparam int EV_LVL_DN = 1;
    localparam int EV_PRESS  = 2;
    localparam int EV_REL    = 3;
    localparam int EV_REP    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    typedef struct {
        int cyc;
        int kind;
        int idx;
    } ev_t;

    ev_t           sb[$];
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    logic [NB-1:0] exp_level = '0;

    // Insert keeping the queue ordered by cycle.
    task automatic push_ev(input int c, input int k, input int i);
        ev_t e;
        int  pos;
        e.cyc = c;
        e.kind = k;
        e.idx = i;
        pos = sb.size();
        for (int j = sb.size() - 1; j >= 0; j--)
            if (sb[j].cyc > c) pos = j;
        sb.insert(pos, e);
    endtask

    // Raw press applied after edge tp, raw release applied after edge tr.
    // Level follows DB+2 edges later; pulses one edge after the level.
    task automatic sched_press(input int i, input int tp, input int tr);
        push_ev(tp + DB + 2, EV_LVL_UP, i);
        push_ev(tp + DB + 3, EV_PRESS, i);
        push_ev(tp + DB + 3, EV_REP, i);
        for (int r = tp + DB + 3 + HC; r < tr + DB + 3; r += RC)
            push_ev(r, EV_REP, i);
        push_ev(tr + DB + 2, EV_LVL_DN, i);
        push_ev(tr + DB + 3, EV_REL, i);
    endtask

    task automatic check_outputs();
        logic [NB-1:0] ep;
        logic [NB-1:0] er;
        logic [NB-1:0] et;
        ev_t           e;
        ep = '0;
        er = '0;
        et = '0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                EV_LVL_UP: exp_level[e.idx] = 1'b1;
                EV_LVL_DN: exp_level[e.idx] = 1'b0;
                EV_PRESS:  ep[e.idx] = 1'b1;
                EV_REL:    er[e.idx] = 1'b1;
                default:   et[e.idx] = 1'b1;
            endcase
        end
        checks++;
        assert (btn_level === exp_level) else begin
            errors++;
            $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, btn_level, exp_level);
        end
        checks++;
        assert (btn_press === ep) else begin
            errors++;
            $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, btn_press, ep);
        end
        checks++;
        assert (btn_release === er) else begin
            errors++;
            $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, btn_release, er);
        end
        checks++;
        assert (btn_repeat === et) else begin
            errors++;
            $error("FAIL repeat cyc=%0d observed=%b expected=%b", cyc, btn_repeat, et);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            check_outputs();
        end
    endtask

    initial begin
        int t;
        rst_n   = 1'b0;
        btn_raw = '0;

        // Reset state
        step(3);
        rst_n = 1'b1;
        step(2);

        // Clean press of U held 40 cycles
        t = cyc;
        btn_raw[BTN_U] = 1'b1;
        sched_press(BTN_U, t, t + 40);
        step(40);
        btn_raw[BTN_U] = 1'b0;
        step(10);

        // Bounce on C: 1,0,1,0 every 2 cycles, then held
        btn_raw[BTN_C] = 1'b1; step(2);
        btn_raw[BTN_C] = 1'b0; step(2);
        btn_raw[BTN_C] = 1'b1; step(2);
        btn_raw[BTN_C] = 1'b0; step(2);
        t = cyc;
        btn_raw[BTN_C] = 1'b1;
        sched_press(BTN_C, t, t + 12);
        step(12);
        btn_raw[BTN_C] = 1'b0;
        step(10);

        // Release D after 8 cycles held
        t = cyc;
        btn_raw[BTN_D] = 1'b1;
        sched_press(BTN_D, t, t + 8);
        step(8);
        btn_raw[BTN_D] = 1'b0;
        step(10);

        // L and R together; L released first, R keeps repeating
        t = cyc;
        btn_raw[BTN_L] = 1'b1;
        btn_raw[BTN_R] = 1'b1;
        sched_press(BTN_L, t, t + 20);
        sched_press(BTN_R, t, t + 40);
        step(20);
        btn_raw[BTN_L] = 1'b0;
        step(20);
        btn_raw[BTN_R] = 1'b0;
        step(10);

        // Reset while U is in REPEAT, U still held afterwards
        t = cyc;
        btn_raw[BTN_U] = 1'b1;
        sched_press(BTN_U, t, t + 1000);
        step(26);
        rst_n = 1'b0;
        #1;
        checks++;
        assert (btn_level === '0) else begin
            errors++;
            $error("FAIL rst_level observed=%b expected=%b", btn_level, 5'b0);
        end
        checks++;
        assert (btn_repeat === '0) else begin
            errors++;
            $error("FAIL rst_repeat observed=%b expected=%b", btn_repeat, 5'b0);
        end
        checks++;
        assert (btn_press === '0 && btn_release === '0) else begin
            errors++;
            $error("FAIL rst_pulses observed=%b/%b expected=0/0", btn_press, btn_release);
        end
        sb.delete();
        exp_level = '0;
        step(3);
        rst_n = 1'b1;
        t = cyc;
        sched_press(BTN_U, t, t + 15);
        step(15);
        btn_raw[BTN_U] = 1'b0;
        step(12);

        // 3-cycle glitch on C never reaches the outputs
        btn_raw[BTN_C] = 1'b1;
        step(3);
        btn_raw[BTN_C] = 1'b0;
        step(10);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Conditions the five raw Basys3 pushbuttons (C, U, L, R, D) before they reach the clock/alarm control logic. Each button goes through:

- a 2-flop synchronizer,
- a counter-based debouncer,
- a per-button state machine that produces a debounced level, a single-cycle press pulse, a release pulse and a hold-to-auto-repeat pulse train.

The downstream time-setting logic consumes `btn_press` for mode changes and `btn_repeat` for increment/decrement. It no longer needs its own 4 Hz sampling counter.

## Interface
- `NUM_BTN`, default 5: number of button channels; bit order {C,U,L,R,D} = [4:0].
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-input cycles required to accept a change (10 ms at 100 MHz); must be ≥2.
- `HOLD_CYCLES`, default 50_000_000: cycles from press pulse to first auto-repeat (500 ms); must be ≥2.
- `REPEAT_CYCLES`, default 25_000_000: auto-repeat period (250 ms, 4 Hz); must be ≥2.
- `clk`, in, 1: 100 MHz system clock. One clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_raw`, in, NUM_BTN: raw asynchronous pushbutton levels, active-high.
- `btn_level`, out, NUM_BTN: debounced level.
- `btn_press`, out, NUM_BTN: one-cycle pulse on each accepted press.
- `btn_release`, out, NUM_BTN: one-cycle pulse on each accepted release.
- `btn_repeat`, out, NUM_BTN: one-cycle pulse on press, then auto-repeat while held.

## Operation
- **Reset:** all outputs 0. Synchronizer flops, debounce counters and hold/repeat counters are cleared, and every FSM goes to IDLE. All of this is asynchronous on `rst_n` low, and applies mid-operation too.
- **Sync:** `btn_raw` → `s1` → `s2`. Reset value is 0 (released).
- **Debounce:**
  - When `s2 == btn_level`, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `btn_level <= s2` and the counter clears.
  - Any bounce back to `btn_level` before that restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` never appear on outputs.
- **FSM per channel:** states IDLE, HOLD, REPEAT.
  - IDLE → HOLD on `btn_level` rising. In that transition cycle, `btn_press` and `btn_repeat` pulse and the hold counter is cleared.
  - HOLD: the counter increments. At `HOLD_CYCLES-1`, `btn_repeat` pulses, the counter clears and the FSM moves to REPEAT.
  - REPEAT: the counter increments. At `REPEAT_CYCLES-1`, `btn_repeat` pulses and the counter clears.
  - HOLD/REPEAT → IDLE on `btn_level` falling. `btn_release` pulses and no `btn_repeat` is issued in that cycle, even if the counter hits its terminal value.
- **Channels:** fully independent. Simultaneous presses on several buttons each produce their own pulses in the same cycle. No priority and no masking.
- **Held through reset:** a button held while `rst_n` deasserts is treated as a new press after debounce.
- **Counter widths:** `$clog2` of the respective parameter. No wrap is possible, because counters are cleared at their terminal value.

## Timing
- `btn_level` rises at cycle `2+DEBOUNCE_CYCLES` after a clean `btn_raw` rise at cycle 0. It falls with the same latency after release.
- `btn_press` and the first `btn_repeat` are asserted in cycle `3+DEBOUNCE_CYCLES`, registered one cycle after the `btn_level` edge.
- Second `btn_repeat`: `HOLD_CYCLES` cycles after the first. Subsequent ones follow every `REPEAT_CYCLES`.
- `btn_release` is asserted one cycle after `btn_level` falls.
- All pulses are exactly one `clk` cycle wide, and all outputs are registered.

## Structure
- Shared package `button_pkg`:
  - FSM state enum: IDLE, HOLD, REPEAT.
  - Button index constants: `BTN_C=4`, `BTN_U=3`, `BTN_L=2`, `BTN_R=1`, `BTN_D=0`.
  - Default timing constants.
- Sub-module `button_channel`: synchronizer, debouncer and FSM for one bit. The top level generates `NUM_BTN` instances.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=10`, `REPEAT_CYCLES=3`.

1. **Clean press of U at cycle 0, held 40 cycles:** `btn_level[3]` rises at cycle 6. `btn_press[3]` and `btn_repeat[3]` pulse at cycle 7. `btn_repeat[3]` pulses again at 17, 20, 23, …
2. **Bounce:** C toggled 1,0,1,0 every 2 cycles, then held. No output activity during the bounce. `btn_press[4]` occurs exactly once, 7 cycles after the final rising edge.
3. **Release:** release D after 8 cycles held. `btn_release[0]` pulses once, 7 cycles after the raw fall. No `btn_repeat[0]` after the first one.
4. **Simultaneous:** L and R pressed in the same cycle. `btn_press[2]` and `btn_press[1]` pulse in the same cycle. Releasing only L leaves R's repeat train uninterrupted.
5. **Reset mid-repeat:** `rst_n` pulled low while U is in REPEAT. All outputs go to 0 immediately. After deassertion with U still held, the sequence is a fresh press 7 cycles later.
6. **Short glitch:** a 3-cycle pulse on `btn_raw[4]` leaves every output at 0 throughout.
